systolic_ctrl: RTL
==================

# systolic_ctrl

Sequencer for the weight-stationary ROWS×COLS systolic array.
- On `start` it loads one weight row per cycle into the array.
- It then streams `n_vec` feature-map vectors and generates the diagonal skew of multiply enables, per-row store enables and per-PE clock-gate enables.
- It flags when each column's accumulated kernel result is valid.
- It sits between the weight/fmap line buffers, which it addresses, and the array, which it drives.

## Interface
- `ROWS`, 5, array rows
- `COLS`, 5, array columns
- `NV_BW`, 8, width of vector count / fmap index
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to run a job; sampled only in IDLE
- `abort`  in  1  synchronous job cancel
- `n_vec`  in  NV_BW  number of fmap vectors; sampled with `start`
- `busy`  out  1  job in progress (not IDLE)
- `done`  out  1  one-cycle pulse at job completion
- `wgt_rd_en`  out  1  weight buffer read strobe (buffer read latency 1)
- `wgt_row`  out  clog2(ROWS)  weight row address
- `fmap_rd_en`  out  1  fmap buffer read strobe (buffer read latency 1)
- `fmap_idx`  out  NV_BW  fmap vector index
- `str_en`  out  ROWS  per-row weight store enable
- `mul_en`  out  ROWS+COLS-1  per-anti-diagonal multiply enable; bit d drives PEs with r+c=d
- `pe_en`  out  ROWS*COLS  per-PE clock-gate enable, bit r*COLS+c
- `out_valid`  out  COLS  column c's bottom-row accumulated result valid

## Operation
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- **IDLE**
  - `start`=1 and `n_vec`≠0: latch `n_vec` and go to LOAD_W.
  - `start` with `n_vec`=0: ignored, no state change.
- **LOAD_W** (ROWS cycles)
  - `wgt_rd_en`=1; `wgt_row` counts 0..ROWS-1.
  - After row ROWS-1, go to STREAM.
- **STREAM** (n_vec cycles)
  - `fmap_rd_en`=1; `fmap_idx` counts 0..n_vec-1.
  - After the last index, go to DRAIN.
- **DRAIN**
  - Hold until the `mul_en` shift chain and `out_valid` are all zero, then go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **Register relationships**
  - `str_en[r]` = `wgt_rd_en` & (`wgt_row`==r), delayed one cycle, so it aligns with buffer data.
  - `mul_en[0]` = `fmap_rd_en` delayed 1; `mul_en[d]` = `mul_en[d-1]` delayed 1 (shift chain).
  - `out_valid[c]` = `mul_en[ROWS-1+c]` delayed 1.
  - `pe_en[r*COLS+c]` = `str_en[r]` | `mul_en[r+c]` | (`mul_en[r+c]` delayed 1). This is combinational from registers; the extra cycle lets the partial sum settle.
- `busy`=1 in every state except IDLE.
- `start` while busy: ignored.
- **`abort`** in any non-IDLE state:
  - Next cycle: IDLE; all strobes, `str_en`, the `mul_en` chain, `out_valid` and counters cleared.
  - No `done` pulse.
  - `abort` and `start` together in IDLE: `abort` wins; the job does not start.
- The job counter wraps never: `fmap_idx` stops at n_vec-1. The maximum `n_vec` is 2^NV_BW-1.

## Timing
- Reset (async assert): state IDLE; `busy`, `done`, `wgt_rd_en`, `wgt_row`, `fmap_rd_en`, `fmap_idx`, `str_en`, `mul_en`, `pe_en`, `out_valid` all 0.
- Reset mid-job behaves identically; the job is lost.
- Let cycle 0 be the cycle `start` is sampled. With R=ROWS, C=COLS, N=n_vec:
  - `wgt_rd_en`: cycles 1..R.
  - `str_en[r]`: cycle r+2.
  - `fmap_rd_en`: cycles R+1..R+N.
  - `mul_en[d]`: cycles R+2+d..R+1+d+N.
  - `out_valid[c]`: cycles 2R+2+c..2R+1+c+N.
  - `done`: cycle 2R+C+N+1.
  - `busy`: cycles 1..2R+C+N+1.
  - Back in IDLE at 2R+C+N+2. The earliest next `start` sample is that cycle.
- `str_en[R-1]` overlapping the first STREAM cycle is legal: it targets a different row than `mul_en`.

## Test plan
- **Reset**: `rst` pulse mid-cycle → all outputs 0 immediately; `busy`=0.
- **Single job**, R=C=5, N=3, `start` at cycle 0:
  - `wgt_rd_en` cycles 1-5; `str_en[4]` at 6; `fmap_rd_en` 6-8.
  - `mul_en[0]` 7-9; `mul_en[8]` 15-17.
  - `out_valid[0]` 12-14; `out_valid[4]` 16-18.
  - `done` at 19; `pe_en[24]` 15-18.
- **N=0 / start while busy**: `start` with `n_vec`=0 → `busy` stays 0. A second `start` at cycle 8 of the N=3 job → ignored; the timeline is unchanged.
- **Abort**: `abort` at cycle 10 of the N=3 job → cycle 11 all outputs 0, `busy`=0, `done` never asserted. A new `start` at 11 runs the full timeline.
- **Max length**: N=255 → `fmap_idx` 0..254 with no wrap; `done` at 2·5+5+255+1=271.
- **Back-to-back jobs**: `start` at the first IDLE cycle after `done` → the second timeline is an exact shift of the first, with no residual `mul_en`/`out_valid`.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// Job/control bundle between a host, the line buffers and the systolic array.
// master: host side (start/abort/n_vec in, status and array controls observed); slave: systolic_ctrl.
interface systolic_ctrl_if #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int NV_BW = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MW = ROWS + COLS - 1;

  logic             start;
  logic             abort;
  logic [NV_BW-1:0] n_vec;
  logic             busy;
  logic             done;
  logic             wgt_rd_en;
  logic [RW-1:0]    wgt_row;
  logic             fmap_rd_en;
  logic [NV_BW-1:0] fmap_idx;
  logic [ROWS-1:0]  str_en;
  logic [MW-1:0]    mul_en;
  logic [ROWS*COLS-1:0] pe_en;
  logic [COLS-1:0]  out_valid;

  modport master (
    output start, abort, n_vec,
    input  busy, done, wgt_rd_en, wgt_row, fmap_rd_en, fmap_idx,
    input  str_en, mul_en, pe_en, out_valid
  );

  modport slave (
    input  start, abort, n_vec,
    output busy, done, wgt_rd_en, wgt_row, fmap_rd_en, fmap_idx,
    output str_en, mul_en, pe_en, out_valid
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-stationary ROWS x COLS systolic array: loads weights,
// streams n_vec fmap vectors, skews multiply enables, gates PEs, flags results.
// Ports: clk, rst (async active-high), bus (systolic_ctrl_if.slave).
module systolic_ctrl #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int NV_BW = 8
) (
  input logic            clk,
  input logic            rst,
  systolic_ctrl_if.slave bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MW = ROWS + COLS - 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_W, STREAM, DRAIN, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NV_BW-1:0] n_vec_q, n_vec_d;
  logic [RW-1:0]    wgt_row_q, wgt_row_d;
  logic [NV_BW-1:0] fmap_idx_q, fmap_idx_d;
  logic [ROWS-1:0]  str_en_q, str_en_d;
  logic [MW-1:0]    mul_en_q, mul_en_d;
  logic [MW-1:0]    mul_dly_q, mul_dly_d;
  logic [COLS-1:0]  out_valid_q, out_valid_d;
  logic             wgt_rd_en;
  logic             fmap_rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_vec_q     <= '0;
      wgt_row_q   <= '0;
      fmap_idx_q  <= '0;
      str_en_q    <= '0;
      mul_en_q    <= '0;
      mul_dly_q   <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      n_vec_q     <= n_vec_d;
      wgt_row_q   <= wgt_row_d;
      fmap_idx_q  <= fmap_idx_d;
      str_en_q    <= str_en_d;
      mul_en_q    <= mul_en_d;
      mul_dly_q   <= mul_dly_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_vec_d    = n_vec_q;
    wgt_row_d  = wgt_row_q;
    fmap_idx_d = fmap_idx_q;
    wgt_rd_en  = (state_q == LOAD_W);
    fmap_rd_en = (state_q == STREAM);

    // Store enable lags the read strobe by the buffer read latency.
    for (int r = 0; r < ROWS; r++) begin
      str_en_d[r] = wgt_rd_en && (wgt_row_q == RW'(r));
    end
    // Anti-diagonal skew: each diagonal fires one cycle after the previous.
    mul_en_d  = {mul_en_q[MW-2:0], fmap_rd_en};
    mul_dly_d = mul_en_q;
    for (int c = 0; c < COLS; c++) begin
      out_valid_d[c] = mul_en_q[ROWS-1+c];
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.n_vec != '0)) begin
          state_d   = LOAD_W;
          n_vec_d   = bus.n_vec;
          wgt_row_d = '0;
        end
      end
      LOAD_W: begin
        if (wgt_row_q == RW'(ROWS - 1)) begin
          state_d    = STREAM;
          wgt_row_d  = '0;
          fmap_idx_d = '0;
        end else begin
          wgt_row_d = wgt_row_q + RW'(1);
        end
      end
      STREAM: begin
        if (fmap_idx_q == n_vec_q - NV_BW'(1)) begin
          state_d    = DRAIN;
          fmap_idx_d = '0;
        end else begin
          fmap_idx_d = fmap_idx_q + NV_BW'(1);
        end
      end
      DRAIN: begin
        // Look at next-cycle values so DONE lands right after the last valid.
        if ((mul_en_d == '0) && (out_valid_d == '0)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d     = IDLE;
      wgt_row_d   = '0;
      fmap_idx_d  = '0;
      str_en_d    = '0;
      mul_en_d    = '0;
      mul_dly_d   = '0;
      out_valid_d = '0;
    end
  end

  // PE stays clocked one cycle past its multiply so the partial sum settles.
  always_comb begin
    bus.pe_en = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.pe_en[r*COLS+c] = str_en_q[r] | mul_en_q[r+c] | mul_dly_q[r+c];
      end
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.wgt_rd_en  = wgt_rd_en;
  assign bus.wgt_row    = wgt_row_q;
  assign bus.fmap_rd_en = fmap_rd_en;
  assign bus.fmap_idx   = fmap_idx_q;
  assign bus.str_en     = str_en_q;
  assign bus.mul_en     = mul_en_q;
  assign bus.out_valid  = out_valid_q;
endmodule
